// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered round-robin arbiter with valid/ready grant handshake and saturating accept counter
module rr_grant_arbiter #(
  parameter int N = 8,
  parameter int IDXW = $clog2(N),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  input  logic            gnt_rdy,
  output logic [CNTW-1:0] gnt_cnt
);
  localparam logic IDLE = 1'b0;
  localparam logic GRANT = 1'b1;
  logic state;
  logic acc;
  logic win_vld;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] nxt_ptr;
  logic [IDXW-1:0] scan_ptr;
  logic [IDXW-1:0] win_idx;
  logic [N-1:0] hi_req;
  assign acc = state == GRANT && gnt_rdy;
  assign nxt_ptr = gnt_idx == IDXW'(N - 1) ? '0 : gnt_idx + 1'b1;
  assign scan_ptr = acc ? nxt_ptr : ptr;
  assign win_vld = |req;
  // lowest request at or above the scan pointer wins, else lowest request overall (wrap)
  always_comb begin
    hi_req = '0;
    win_idx = '0;
    for (int i = 0; i < N; i++) hi_req[i] = req[i] && IDXW'(i) >= scan_ptr;
    for (int i = N - 1; i >= 0; i--) win_idx = req[i] ? IDXW'(i) : win_idx;
    for (int i = N - 1; i >= 0; i--) win_idx = hi_req[i] ? IDXW'(i) : win_idx;
  end
  // grant register: load from IDLE or on accept, hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr <= '0;
    end else if (state == IDLE || gnt_rdy) begin
      if (acc) ptr <= nxt_ptr;
      state <= win_vld ? GRANT : IDLE;
      gnt_vld <= win_vld;
      gnt_idx <= win_vld ? win_idx : '0;
      gnt <= win_vld ? {{(N-1){1'b0}}, 1'b1} << win_idx : '0;
    end
  end
  // saturating count of accepted grants
  always_ff @(posedge clk) begin
    if (rst) gnt_cnt <= '0;
    else if (acc && ~&gnt_cnt) gnt_cnt <= gnt_cnt + 1'b1;
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed checks plus per-cycle comparison against a modulo-arithmetic reference model
module tb_rr_grant_arbiter;
  typedef struct {bit vld; int idx; int ptr; int cnt;} mst_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] req_a, gnt_a, req_c, gnt_c;
  logic [4:0] req_b, gnt_b;
  logic [2:0] idx_a, idx_b, idx_c;
  logic vld_a, vld_b, vld_c, rdy_a, rdy_b, rdy_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  mst_t m_a = '{0, 0, 0, 0};
  mst_t m_b = '{0, 0, 0, 0};
  mst_t m_c = '{0, 0, 0, 0};
  always #5 clk = ~clk;
  rr_grant_arbiter #(.N(8), .CNTW(16)) u_a (.clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .gnt_rdy(rdy_a), .gnt_cnt(cnt_a));
  rr_grant_arbiter #(.N(5), .CNTW(16)) u_b (.clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .gnt_rdy(rdy_b), .gnt_cnt(cnt_b));
  rr_grant_arbiter #(.N(8), .CNTW(4)) u_c (.clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c), .gnt_vld(vld_c), .gnt_rdy(rdy_c), .gnt_cnt(cnt_c));
  function automatic mst_t step(mst_t s, logic [63:0] r, bit rdy, bit rs, int n, int cmax);
    mst_t o = s;
    int w = -1;
    if (rs) return '{0, 0, 0, 0};
    if (s.vld && !rdy) return o;
    if (s.vld) begin
      o.ptr = (s.idx + 1) % n;
      if (o.cnt < cmax) o.cnt++;
    end
    for (int k = 0; k < n; k++) if (w < 0 && r[(o.ptr + k) % n]) w = (o.ptr + k) % n;
    o.vld = w >= 0;
    o.idx = w < 0 ? 0 : w;
    return o;
  endfunction
  always @(posedge clk) begin
    m_a <= step(m_a, 64'(req_a), rdy_a, rst, 8, 65535);
    m_b <= step(m_b, 64'(req_b), rdy_b, rst, 5, 65535);
    m_c <= step(m_c, 64'(req_c), rdy_c, rst, 8, 15);
  end
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp(string t, logic [63:0] g, int idx, bit vld, int cnt, mst_t m);
    chk({t, ".gnt"}, g, m.vld ? 64'd1 << m.idx : 64'd0);
    chk({t, ".idx"}, idx, m.idx);
    chk({t, ".vld"}, vld, m.vld);
    chk({t, ".cnt"}, cnt, m.cnt);
    chk({t, ".onehot"}, $countones(g) <= 1, 1);
    chk({t, ".vld_or"}, vld, |g);
    if (vld) chk({t, ".gnt_at_idx"}, g[idx], 1);
  endtask
  always @(negedge clk) if (chk_en) begin
    cmp("a", 64'(gnt_a), int'(idx_a), vld_a, int'(cnt_a), m_a);
    cmp("b", 64'(gnt_b), int'(idx_b), vld_b, int'(cnt_b), m_b);
    cmp("c", 64'(gnt_c), int'(idx_c), vld_c, int'(cnt_c), m_c);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    {req_a, req_b, req_c} = '0;
    {rdy_a, rdy_b, rdy_c} = '0;
    cyc();
    cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    rdy_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_vld", vld_a, 0);
      chk("idle_gnt", gnt_a, 0);
      chk("idle_idx", idx_a, 0);
      chk("idle_cnt", cnt_a, 0);
    end
    req_a = 8'h81;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("alt_idx", idx_a, i % 2 ? 7 : 0);
      chk("alt_gnt", gnt_a, i % 2 ? 8'h80 : 8'h01);
      chk("alt_cnt", cnt_a, i);
    end
    req_a = 8'h00;
    cyc();
    chk("alt_end_vld", vld_a, 0);
    chk("alt_end_cnt", cnt_a, 8);
    do_rst();
    req_a = 8'h04;
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req_a = 8'h10;
      cyc();
      chk("bp_gnt", gnt_a, 8'h04);
      chk("bp_idx", idx_a, 2);
    end
    rdy_a = 1'b1;
    cyc();
    rdy_a = 1'b0;
    chk("bp_acc_gnt", gnt_a, 8'h10);
    chk("bp_acc_idx", idx_a, 4);
    chk("bp_acc_cnt", cnt_a, 1);
    req_a = 8'h40;
    rdy_a = 1'b1;
    cyc();
    chk("wrap_idx6", idx_a, 6);
    req_a = 8'h41;
    cyc();
    chk("wrap_idx0", idx_a, 0);
    cyc();
    chk("wrap_idx6b", idx_a, 6);
    chk("wrap_cnt", cnt_a, 4);
    req_a = 8'h00;
    cyc();
    chk("wrap_end_vld", vld_a, 0);
    chk("wrap_end_cnt", cnt_a, 5);
    do_rst();
    req_a = 8'hFF;
    req_b = 5'h1F;
    req_c = 8'hFF;
    {rdy_b, rdy_c} = 2'b11;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (i <= 10) begin
        chk("full_idx", idx_a, i % 8);
        chk("full_cnt", cnt_a, i);
      end
      if (i < 6) chk("n5_idx", idx_b, i % 5);
      chk("sat_cnt", cnt_c, i < 15 ? i : 15);
    end
    {req_a, req_b, req_c} = '0;
    do_rst();
    req_a = 8'h08;
    rdy_a = 1'b0;
    cyc();
    chk("mid_pre_idx", idx_a, 3);
    chk("mid_pre_vld", vld_a, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_vld", vld_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_gnt", gnt_a, 0);
    cyc();
    chk("mid_back_vld", vld_a, 1);
    chk("mid_back_idx", idx_a, 3);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Registered round-robin arbiter over N request lines, with a valid/ready handshake on the grant.
- Produces a one-hot grant vector for the one-hot checker and encoder stages downstream, plus its pre-encoded index.
- Holds each grant stable until the consumer accepts it, then advances the priority pointer past the winner.
- Keeps a saturating count of accepted grants for debug.

Parameters:
- N, 8, number of requesters; legal range 2..64, power of two not required.
- IDXW, `CLOG2(N), width of the grant index and pointer.
- CNTW, 16, width of the saturating accepted-grant counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector; bit i = requester i wants service.
- gnt  output  N  registered one-hot grant; all zeros when gnt_vld=0.
- gnt_idx  output  IDXW  binary index of the set bit in gnt; 0 when gnt_vld=0.
- gnt_vld  output  1  a grant is being presented.
- gnt_rdy  input  1  consumer accepts the grant this cycle.
- gnt_cnt  output  CNTW  number of accepted grants, saturating at all-ones.

Behaviour:
- Reset (rst=1 at a clock edge): gnt=0, gnt_idx=0, gnt_vld=0, ptr=0, gnt_cnt=0, state=IDLE.
  - rst has priority over every other event, including a grant in flight; that grant is dropped without acceptance.
- Winner selection (combinational, internal):
  - First i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - No winner if req=0.
- State machine, two states:
  - IDLE: gnt_vld=0. If req!=0, the next edge loads gnt=onehot(winner), gnt_idx=winner, gnt_vld=1 and moves to GRANT. Latency: req to gnt_vld is 1 cycle.
  - GRANT with gnt_rdy=0: gnt, gnt_idx and gnt_vld hold unchanged. Changes on req, including deassertion by the granted requester, are ignored (no retraction). ptr holds.
  - GRANT with gnt_rdy=1 (accept): ptr <= (gnt_idx==N-1) ? 0 : gnt_idx+1. gnt_cnt increments unless saturated.
    - Same edge re-arbitration uses the current req and the new ptr.
    - If a winner exists, load the new grant and stay in GRANT, giving back-to-back grants at one per cycle.
    - If no winner exists, clear gnt, gnt_idx and gnt_vld and go to IDLE.
- gnt_rdy in IDLE: ignored; no counter or pointer change.
- Invariants, every cycle:
  - gnt has at most one bit set.
  - gnt_vld = |gnt.
  - gnt[gnt_idx]=1 whenever gnt_vld=1.
- Width rules:
  - ptr and idx arithmetic wraps at N, not at 2**IDXW; no index >= N is ever produced.
  - gnt_cnt saturates at 2**CNTW-1 and never wraps.
- Fairness: with all N requesting continuously and gnt_rdy=1, each requester is granted exactly once per N accepts.

Test Plan:
- Reset/idle: after rst with req=0, gnt_rdy=1 for 10 cycles -> gnt_vld=0, gnt=0, gnt_idx=0, gnt_cnt=0 throughout.
- Alternation, N=8: req=8'h81 held, gnt_rdy=1 -> from cycle 1, gnt_idx sequence is 0,7,0,7,...; gnt is 8'h01/8'h80; gnt_cnt +1 per cycle.
- Backpressure: req=8'h04, gnt_rdy=0 for 5 cycles, req changed to 8'h10 in cycle 2 -> gnt=8'h04, gnt_idx=2 held all 5 cycles. Then gnt_rdy=1 for one cycle -> next cycle gnt=8'h10, gnt_idx=4, gnt_cnt=1.
- Full load / wrap: req=8'hFF, gnt_rdy=1 for 10 cycles -> gnt_idx 0,1,...,7,0,1; gnt_cnt=10. With N=5 and req=5'h1F -> gnt_idx 0,1,2,3,4,0.
- Pointer wrap search: after an accept at idx 6 (ptr=7), req=8'h41 -> next grant is idx 0, then idx 6.
- Reset mid-grant: gnt_vld=1, gnt_idx=3, gnt_rdy=0, rst pulsed 1 cycle -> next cycle gnt_vld=0, gnt_cnt=0. With req=8'h08 still high, the grant returns at idx 3 one cycle after rst drops.
- Counter saturation, CNTW=4: 20 accepts -> gnt_cnt=15 and stays at 15.
